chacha_mem_arbiter: RTL and testbench
=====================================

Name: chacha_mem_arbiter

Overview:
- Two-master arbiter sharing the single-port on-chip program/data RAM between the Nios CPU data master (cpu_*) and the ChaCha20 accelerator block-fetch master (acc_*).
- Grants at most one access per cycle and uses round-robin with a bounded hold so the accelerator can stream a full 16-word ChaCha state without starving the CPU.
- Tracks the RAM's one-cycle read latency and routes readdatavalid back to the issuing master.

Parameters:
- ADDR_W, 16, word address width (65536 x 32-bit RAM).
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- MAX_HOLD, 16, maximum consecutive grants to one master while the other is requesting; must be >= 1.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_address  in  ADDR_W  CPU word address.
- cpu_byteenable  in  DATA_W/8  CPU byte lanes.
- cpu_read  in  1  CPU read request.
- cpu_write  in  1  CPU write request.
- cpu_writedata  in  DATA_W  CPU write data.
- cpu_waitrequest  out  1  CPU stall; low means the command is accepted this cycle.
- cpu_readdata  out  DATA_W  CPU read data.
- cpu_readdatavalid  out  1  cpu_readdata is valid.
- acc_address, acc_byteenable, acc_read, acc_write, acc_writedata, acc_waitrequest, acc_readdata, acc_readdatavalid: identical to the cpu_* ports, for the accelerator.
- ram_address  out  ADDR_W  to RAM address.
- ram_byteenable  out  DATA_W/8  to RAM byteenable.
- ram_chipselect  out  1  RAM access strobe.
- ram_write  out  1  RAM write strobe.
- ram_writedata  out  DATA_W  to RAM writedata.
- ram_readdata  in  DATA_W  RAM output; unregistered output, valid the cycle after the address is sampled.

Behaviour:
- Request: req_x = x_read | x_write. If read and write are both high, the access is a write and the read is ignored.
- State registers:
  - last: CPU/ACC, reset value ACC.
  - hold_cnt: width clog2(MAX_HOLD+1), reset value 0.
  - rv_cpu, rv_acc: read-valid pipeline bits, reset value 0.
- Grant (combinational from the registers and the current requests):
  - Only one master requesting: grant that master.
  - Both requesting: if 0 < hold_cnt < MAX_HOLD, grant last; otherwise grant the master that is not last.
  - Neither requesting: no grant.
  - While reset_n is low: no grant.
- Granted master: waitrequest = 0 in the same cycle.
- Every other master: waitrequest = 1, whether or not it is requesting; both waitrequests are 1 during reset.
- RAM drive:
  - On a grant: ram_chipselect = 1, ram_write = granted write, and address, byteenable and writedata are muxed from the granted master.
  - With no grant: ram_chipselect = 0 and ram_write = 0; ram_address, ram_byteenable and ram_writedata hold the CPU values. They are don't-care but must be deterministic.
- Register update at each posedge:
  - Grant to the same master as last: hold_cnt increments, saturating at MAX_HOLD.
  - Grant to the other master: last is updated and hold_cnt = 1.
  - No grant: hold_cnt = 0 and last is unchanged.
- Read return:
  - rv_cpu is set to (grant CPU & read & ~write); rv_acc likewise for the accelerator.
  - cpu_readdatavalid = rv_cpu and acc_readdatavalid = rv_acc, both registered, with exactly one cycle of latency.
  - Both readdata outputs pass ram_readdata straight through.
  - Back-to-back reads, including reads alternating between masters every cycle, sustain 1 word/cycle.
  - At most one readdatavalid is high in any cycle.
- Writes produce no readdatavalid. A read of the same address in the following cycle returns the new data (RAM behaviour is not relied on within the same cycle).
- MAX_HOLD = 1 gives strict alternation under contention.
- Reset mid-operation:
  - Asserting reset_n low clears all registers immediately.
  - An in-flight read never returns readdatavalid.
  - Grants resume on the first edge after reset_n rises.
- Both masters must keep their command stable while waitrequest = 1 (Avalon-MM). The arbiter does not latch commands.

Test Plan:
- Reset: hold reset_n low with both masters requesting -> both waitrequest = 1, ram_chipselect = 0, both readdatavalid = 0; last = ACC, hold_cnt = 0.
- CPU-only read of address 0x0010, RAM holding 0xDEADBEEF:
  - Same cycle: ram_address = 0x0010, ram_chipselect = 1, cpu_waitrequest = 0.
  - Next cycle: cpu_readdatavalid = 1 with cpu_readdata = 0xDEADBEEF; acc_readdatavalid stays 0.
- Continuous reads from both masters with MAX_HOLD = 16 after reset -> CPU granted 16 cycles, then ACC 16 cycles, then CPU 16, ...; each readdatavalid follows its own grant by 1 cycle; 100% RAM utilisation.
- MAX_HOLD = 1 with both masters reading -> grants alternate CPU, ACC, CPU, ... every cycle; readdatavalid alternates correspondingly.
- Write/read contention with last = CPU, hold_cnt = 0: ACC writes 0x12345678 to 0x0100 with byteenable 4'b0011 while the CPU reads 0x0100:
  - Cycle 1: ACC granted, ram_write = 1, ram_byteenable = 4'b0011, cpu_waitrequest = 1.
  - Cycle 2: CPU granted.
  - Cycle 3: cpu_readdata low half = 0x5678, upper half unchanged.
- Reset during a read: CPU read granted, then reset_n pulled low before the next edge -> cpu_readdatavalid never asserts; after release, a fresh CPU read completes normally with 1-cycle latency.

Source files
------------

// File: rtl/chacha_mem_arbiter.sv
// Round-robin arbiter with bounded hold that shares one single-port RAM between the
// CPU data master and the ChaCha20 block-fetch master, and routes read returns back.
module chacha_mem_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 16
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [ADDR_W-1:0]               cpu_address,
    input  logic [DATA_W/8-1:0]             cpu_byteenable,
    input  logic                            cpu_read,
    input  logic                            cpu_write,
    input  logic [DATA_W-1:0]               cpu_writedata,
    output logic                            cpu_waitrequest,
    output logic [DATA_W-1:0]               cpu_readdata,
    output logic                            cpu_readdatavalid,
    input  logic [ADDR_W-1:0]               acc_address,
    input  logic [DATA_W/8-1:0]             acc_byteenable,
    input  logic                            acc_read,
    input  logic                            acc_write,
    input  logic [DATA_W-1:0]               acc_writedata,
    output logic                            acc_waitrequest,
    output logic [DATA_W-1:0]               acc_readdata,
    output logic                            acc_readdatavalid,
    output logic [ADDR_W-1:0]               ram_address,
    output logic [DATA_W/8-1:0]             ram_byteenable,
    output logic                            ram_chipselect,
    output logic                            ram_write,
    output logic [DATA_W-1:0]               ram_writedata,
    input  logic [DATA_W-1:0]               ram_readdata,
    output logic                            dbg_last_o,
    output logic [$clog2(MAX_HOLD+1)-1:0]   dbg_hold_cnt_o
);

    localparam int              HC_W     = $clog2(MAX_HOLD + 1);
    localparam logic [HC_W-1:0] HOLD_MAX = HC_W'(MAX_HOLD);

    typedef enum logic {
        SEL_CPU = 1'b0,
        SEL_ACC = 1'b1
    } sel_e;

    // Handshake: a master's command is taken in the cycle its waitrequest is low; while
    // waitrequest is high it must hold the command stable, nothing is latched here.
    logic            req_cpu, req_acc;
    logic            gnt_any, gnt_cpu, gnt_acc;
    sel_e            gnt_sel;
    sel_e            last_q, last_d;
    logic [HC_W-1:0] hold_q, hold_d;
    logic            rv_cpu_q, rv_cpu_d;
    logic            rv_acc_q, rv_acc_d;

    assign req_cpu = cpu_read | cpu_write;
    assign req_acc = acc_read | acc_write;

    always_comb begin
        gnt_any = 1'b0;
        gnt_sel = SEL_CPU;
        if (reset_n) begin
            if (req_cpu && req_acc) begin
                gnt_any = 1'b1;
                // Keep the current owner only while its burst is live and under the cap.
                if (hold_q != '0 && hold_q < HOLD_MAX) gnt_sel = last_q;
                else                                   gnt_sel = sel_e'(~last_q);
            end else if (req_cpu) begin
                gnt_any = 1'b1;
                gnt_sel = SEL_CPU;
            end else if (req_acc) begin
                gnt_any = 1'b1;
                gnt_sel = SEL_ACC;
            end
        end
    end

    assign gnt_cpu = gnt_any && (gnt_sel == SEL_CPU);
    assign gnt_acc = gnt_any && (gnt_sel == SEL_ACC);

    always_comb begin
        last_d = last_q;
        hold_d = hold_q;
        if (!gnt_any) begin
            hold_d = '0;
        end else if (gnt_sel == last_q) begin
            if (hold_q != HOLD_MAX) hold_d = hold_q + HC_W'(1);
        end else begin
            last_d = gnt_sel;
            hold_d = HC_W'(1);
        end
        rv_cpu_d = gnt_cpu & cpu_read & ~cpu_write;
        rv_acc_d = gnt_acc & acc_read & ~acc_write;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q   <= SEL_ACC;
            hold_q   <= '0;
            rv_cpu_q <= 1'b0;
            rv_acc_q <= 1'b0;
        end else begin
            last_q   <= last_d;
            hold_q   <= hold_d;
            rv_cpu_q <= rv_cpu_d;
            rv_acc_q <= rv_acc_d;
        end
    end

    assign cpu_waitrequest   = ~gnt_cpu;
    assign acc_waitrequest   = ~gnt_acc;
    assign cpu_readdatavalid = rv_cpu_q;
    assign acc_readdatavalid = rv_acc_q;
    assign cpu_readdata      = ram_readdata;
    assign acc_readdata      = ram_readdata;

    // Idle cycles park the datapath on the CPU inputs so the RAM pins stay deterministic.
    assign ram_chipselect = gnt_any;
    assign ram_write      = (gnt_cpu & cpu_write) | (gnt_acc & acc_write);
    assign ram_address    = gnt_acc ? acc_address    : cpu_address;
    assign ram_byteenable = gnt_acc ? acc_byteenable : cpu_byteenable;
    assign ram_writedata  = gnt_acc ? acc_writedata  : cpu_writedata;

    assign dbg_last_o     = last_q;
    assign dbg_hold_cnt_o = hold_q;

endmodule

// File: tb/tb_chacha_mem_arbiter.sv
// Directed bench: two arbiter instances (MAX_HOLD 16 and 1) share one stimulus stream,
// each with its own behavioural single-port RAM.
module tb_chacha_mem_arbiter;

    logic        clk;
    logic        reset_n;
    logic [15:0] cpu_address, acc_address;
    logic [3:0]  cpu_byteenable, acc_byteenable;
    logic        cpu_read, cpu_write, acc_read, acc_write;
    logic [31:0] cpu_writedata, acc_writedata;

    logic        h_cpu_wr, h_cpu_rdv, h_acc_wr, h_acc_rdv, h_cs, h_we, h_last;
    logic [31:0] h_cpu_rd, h_acc_rd, h_wd, h_rd;
    logic [15:0] h_addr;
    logic [3:0]  h_be;
    logic [4:0]  h_hold;

    logic        s_cpu_wr, s_cpu_rdv, s_acc_wr, s_acc_rdv, s_cs, s_we, s_last;
    logic [31:0] s_cpu_rd, s_acc_rd, s_wd, s_rd;
    logic [15:0] s_addr;
    logic [3:0]  s_be;
    logic [0:0]  s_hold;

    logic [31:0] mem_h [0:1023];
    logic [31:0] mem_s [0:1023];

    int n_cmp  = 0;
    int n_fail = 0;

    chacha_mem_arbiter #(.ADDR_W(16), .DATA_W(32), .MAX_HOLD(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_address(cpu_address), .cpu_byteenable(cpu_byteenable), .cpu_read(cpu_read),
        .cpu_write(cpu_write), .cpu_writedata(cpu_writedata), .cpu_waitrequest(h_cpu_wr),
        .cpu_readdata(h_cpu_rd), .cpu_readdatavalid(h_cpu_rdv),
        .acc_address(acc_address), .acc_byteenable(acc_byteenable), .acc_read(acc_read),
        .acc_write(acc_write), .acc_writedata(acc_writedata), .acc_waitrequest(h_acc_wr),
        .acc_readdata(h_acc_rd), .acc_readdatavalid(h_acc_rdv),
        .ram_address(h_addr), .ram_byteenable(h_be), .ram_chipselect(h_cs),
        .ram_write(h_we), .ram_writedata(h_wd), .ram_readdata(h_rd),
        .dbg_last_o(h_last), .dbg_hold_cnt_o(h_hold)
    );

    chacha_mem_arbiter #(.ADDR_W(16), .DATA_W(32), .MAX_HOLD(1)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .cpu_address(cpu_address), .cpu_byteenable(cpu_byteenable), .cpu_read(cpu_read),
        .cpu_write(cpu_write), .cpu_writedata(cpu_writedata), .cpu_waitrequest(s_cpu_wr),
        .cpu_readdata(s_cpu_rd), .cpu_readdatavalid(s_cpu_rdv),
        .acc_address(acc_address), .acc_byteenable(acc_byteenable), .acc_read(acc_read),
        .acc_write(acc_write), .acc_writedata(acc_writedata), .acc_waitrequest(s_acc_wr),
        .acc_readdata(s_acc_rd), .acc_readdatavalid(s_acc_rdv),
        .ram_address(s_addr), .ram_byteenable(s_be), .ram_chipselect(s_cs),
        .ram_write(s_we), .ram_writedata(s_wd), .ram_readdata(s_rd),
        .dbg_last_o(s_last), .dbg_hold_cnt_o(s_hold)
    );

    // Clock / reset generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAMs: address sampled at the edge, data held on the output afterwards
    always @(posedge clk) begin
        if (h_cs) begin
            if (h_we) begin
                for (int b = 0; b < 4; b++)
                    if (h_be[b]) mem_h[h_addr[9:0]][8*b +: 8] <= h_wd[8*b +: 8];
            end else begin
                h_rd <= mem_h[h_addr[9:0]];
            end
        end
    end

    always @(posedge clk) begin
        if (s_cs) begin
            if (s_we) begin
                for (int b = 0; b < 4; b++)
                    if (s_be[b]) mem_s[s_addr[9:0]][8*b +: 8] <= s_wd[8*b +: 8];
            end else begin
                s_rd <= mem_s[s_addr[9:0]];
            end
        end
    end

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_read = 1'b0; cpu_write = 1'b0; acc_read = 1'b0; acc_write = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic exp_c, exp_c1, prev_c, prev_c1;
        prev_c  = 1'b0;
        prev_c1 = 1'b0;
        reset_n = 1'b1;
        cpu_address = 16'h0; acc_address = 16'h0;
        cpu_byteenable = 4'hF; acc_byteenable = 4'hF;
        cpu_writedata = 32'h0; acc_writedata = 32'h0;
        cpu_read = 1'b1; cpu_write = 1'b0; acc_read = 1'b1; acc_write = 1'b0;
        #1 reset_n = 1'b0;

        // Reset with both masters requesting
        step(); step();
        chk("rst_cpu_wr", h_cpu_wr, 1);
        chk("rst_acc_wr", h_acc_wr, 1);
        chk("rst_cs", h_cs, 0);
        chk("rst_cpu_rdv", h_cpu_rdv, 0);
        chk("rst_acc_rdv", h_acc_rdv, 0);
        chk("rst_last", h_last, 1);
        chk("rst_hold", h_hold, 0);
        chk("rst1_cpu_wr", s_cpu_wr, 1);
        chk("rst1_cs", s_cs, 0);

        idle();
        reset_n = 1'b1;
        step();

        // Preload RAM through the CPU port
        cpu_write = 1'b1; cpu_address = 16'h0010; cpu_writedata = 32'hDEADBEEF;
        #1;
        chk("wr_cpu_wr", h_cpu_wr, 0);
        chk("wr_ram_we", h_we, 1);
        step();
        cpu_address = 16'h0100; cpu_writedata = 32'hAAAABBBB;
        step();
        idle();
        #1;
        chk("wr_no_rdv", h_cpu_rdv, 0);
        step();

        // CPU-only read of 0x0010
        cpu_read = 1'b1; cpu_address = 16'h0010;
        #1;
        chk("rd_addr", h_addr, 32'h0010);
        chk("rd_cs", h_cs, 1);
        chk("rd_cpu_wr", h_cpu_wr, 0);
        step();
        idle();
        #1;
        chk("rd_cpu_rdv", h_cpu_rdv, 1);
        chk("rd_cpu_data", h_cpu_rd, 32'hDEADBEEF);
        chk("rd_acc_rdv", h_acc_rdv, 0);
        step();
        chk("rd_rdv_drop", h_cpu_rdv, 0);
        chk("idle_last_cpu", h_last, 0);
        chk("idle_hold0", h_hold, 0);

        // Contention: ACC partial write vs CPU read of 0x0100 (last = CPU, hold = 0)
        acc_write = 1'b1; acc_address = 16'h0100; acc_writedata = 32'h12345678;
        acc_byteenable = 4'b0011;
        cpu_read = 1'b1; cpu_address = 16'h0100;
        #1;
        chk("ct1_acc_wr", h_acc_wr, 0);
        chk("ct1_ram_we", h_we, 1);
        chk("ct1_ram_be", h_be, 4'b0011);
        chk("ct1_cpu_wr", h_cpu_wr, 1);
        step();
        acc_write = 1'b0;
        #1;
        chk("ct2_cpu_wr", h_cpu_wr, 0);
        chk("ct2_addr", h_addr, 32'h0100);
        chk("ct2_acc_rdv", h_acc_rdv, 0);
        step();
        idle();
        #1;
        chk("ct3_cpu_rdv", h_cpu_rdv, 1);
        chk("ct3_cpu_data", h_cpu_rd, 32'hAAAA5678);
        step();

        // CPU alone for 20 cycles: hold counter saturates, then ACC wins at once
        cpu_read = 1'b1; cpu_address = 16'h0010;
        for (int i = 0; i < 20; i++) step();
        chk("sat_hold", h_hold, 16);
        chk("sat1_hold", s_hold, 1);
        acc_read = 1'b1; acc_address = 16'h0100; acc_byteenable = 4'hF;
        #1;
        chk("sat_acc_wr", h_acc_wr, 0);
        chk("sat_cpu_wr", h_cpu_wr, 1);
        idle();

        // Fresh reset, then both masters stream reads
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        cpu_read = 1'b1; acc_read = 1'b1;
        for (int i = 0; i < 48; i++) begin
            exp_c  = ((i / 16) % 2) == 0;
            exp_c1 = (i % 2) == 0;
            #1;
            if (i > 0) begin
                chk($sformatf("st_cpu_rdv_%0d", i), h_cpu_rdv, prev_c);
                chk($sformatf("st_acc_rdv_%0d", i), h_acc_rdv, !prev_c);
                chk($sformatf("st1_cpu_rdv_%0d", i), s_cpu_rdv, prev_c1);
                chk($sformatf("st1_acc_rdv_%0d", i), s_acc_rdv, !prev_c1);
            end
            chk($sformatf("st_cs_%0d", i), h_cs, 1);
            chk($sformatf("st_cpu_wr_%0d", i), h_cpu_wr, !exp_c);
            chk($sformatf("st_acc_wr_%0d", i), h_acc_wr, exp_c);
            chk($sformatf("st1_cpu_wr_%0d", i), s_cpu_wr, !exp_c1);
            chk($sformatf("st1_acc_wr_%0d", i), s_acc_wr, exp_c1);
            prev_c  = exp_c;
            prev_c1 = exp_c1;
            step();
        end
        idle();
        #1;
        chk("st_last_cpu_rdv", h_cpu_rdv, prev_c);
        chk("st_last_acc_rdv", h_acc_rdv, !prev_c);
        step();

        // Reset while a CPU read is in flight
        cpu_read = 1'b1; cpu_address = 16'h0010;
        #1;
        chk("rr_cpu_wr", h_cpu_wr, 0);
        #2;
        reset_n = 1'b0;
        idle();
        step();
        chk("rr_rdv0", h_cpu_rdv, 0);
        chk("rr1_rdv0", s_cpu_rdv, 0);
        step();
        chk("rr_rdv1", h_cpu_rdv, 0);
        reset_n = 1'b1;
        cpu_read = 1'b1;
        #1;
        chk("rr_resume_wr", h_cpu_wr, 0);
        step();
        idle();
        #1;
        chk("rr_resume_rdv", h_cpu_rdv, 1);
        chk("rr_resume_data", h_cpu_rd, 32'hDEADBEEF);
        chk("rr1_resume_rdv", s_cpu_rdv, 1);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
